// File: rtl/pcmon_pkg.sv
// ---------------------------------------------------------------------------
// pcmon_pkg
// Shared types and constants for the program-counter stall monitor.
//   pcmon_state_t    : per-channel watchdog state (IDLE / TRACK / ALARM)
//   PCMON_THRESH_DEF : suggested default stall threshold in qualified cycles
//   PCMON_TS_W       : width of the optional first-alarm timestamp
// ---------------------------------------------------------------------------
package pcmon_pkg;

    typedef enum logic [1:0] {
        PCMON_IDLE  = 2'd0,
        PCMON_TRACK = 2'd1,
        PCMON_ALARM = 2'd2
    } pcmon_state_t;

    localparam int PCMON_THRESH_DEF = 25;
    localparam int PCMON_TS_W       = 32;

endpackage

// File: rtl/pcmon_chan.sv
// ---------------------------------------------------------------------------
// pcmon_chan
// One watchdog channel: remembers the last PC seen and counts consecutive
// qualified cycles on which the PC stays the same. It flags a hit on the
// cycle whose next count reaches the threshold.
// Ports:
//   clk, res_n    : CPU clock, asynchronous active-low reset
//   upd_i         : qualified cycle (global enable AND channel valid)
//   pc_i          : this channel's program counter
//   thresh_i      : stall threshold, 0 disables detection
//   clear_i       : returns an alarmed channel to TRACK with count 0
//   hit_o         : combinational, channel alarms on the coming edge
//   strobe_o      : registered one-cycle pulse on the alarming edge
//   alarm_o       : registered sticky alarm (state is ALARM)
//   alarm_nxt_o   : alarm state the channel takes on the coming edge
// ---------------------------------------------------------------------------
module pcmon_chan
    import pcmon_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int THRESH_W = 16
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                upd_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [THRESH_W-1:0] thresh_i,
    input  logic                clear_i,
    output logic                hit_o,
    output logic                strobe_o,
    output logic                alarm_o,
    output logic                alarm_nxt_o
);

    pcmon_state_t        state;
    pcmon_state_t        state_nxt;
    logic [PC_W-1:0]     sample;
    logic [PC_W-1:0]     sample_nxt;
    logic [THRESH_W-1:0] cnt;
    logic [THRESH_W-1:0] cnt_nxt;
    logic [THRESH_W-1:0] cnt_inc;
    logic                hit;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= PCMON_IDLE;
            sample   <= '0;
            cnt      <= '0;
            strobe_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            sample   <= sample_nxt;
            cnt      <= cnt_nxt;
            strobe_o <= hit;
        end
    end

    // ALARM keeps tracking like TRACK so the count stays meaningful, but
    // only a TRACK channel can produce a new hit. Clear only touches
    // channels already in ALARM, so a same-edge hit from TRACK still wins.
    always_comb begin
        cnt_inc    = (cnt == {THRESH_W{1'b1}}) ? cnt : cnt + THRESH_W'(1);
        state_nxt  = state;
        sample_nxt = sample;
        cnt_nxt    = cnt;
        hit        = 1'b0;
        if (upd_i) begin
            if (state == PCMON_IDLE) begin
                sample_nxt = pc_i;
                cnt_nxt    = '0;
                state_nxt  = PCMON_TRACK;
            end else begin
                if (pc_i == sample) begin
                    cnt_nxt = cnt_inc;
                end else begin
                    sample_nxt = pc_i;
                    cnt_nxt    = '0;
                end
                if ((state == PCMON_TRACK) && (thresh_i != '0) && (cnt_nxt >= thresh_i)) begin
                    hit       = 1'b1;
                    state_nxt = PCMON_ALARM;
                end
            end
        end
        if (clear_i && (state == PCMON_ALARM)) begin
            state_nxt = PCMON_TRACK;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        hit_o       = hit;
        alarm_o     = (state == PCMON_ALARM);
        alarm_nxt_o = (state_nxt == PCMON_ALARM);
    end

endmodule

// File: rtl/pc_stall_monitor.sv
// ---------------------------------------------------------------------------
// pc_stall_monitor
// Program-counter stall watchdog for CH channels. Each channel raises a
// one-cycle strobe and a sticky alarm when its PC has been held for
// thresh_i qualified cycles; the PC and channel of the first alarm are
// captured for post-mortem readout.
// Ports:
//   clk, res_n   : CPU clock, asynchronous active-low reset
//   en_i         : global enable, low freezes all channels
//   pc_i         : packed PCs, channel c at [c*PC_W +: PC_W]
//   valid_i      : per-channel qualifier, low freezes that channel
//   thresh_i     : stall threshold, 0 disables detection
//   clear_i      : clears alarms and capture registers
//   strobe_o     : per-channel threshold-reached pulse
//   alarm_o      : per-channel sticky alarm
//   alarm_any_o  : OR of all alarms
//   stall_pc_o   : PC of the first alarmed channel
//   stall_ch_o   : index of the first alarmed channel
//   stall_ts_o   : cycle timestamp of the first alarm
// Build option: define PCMON_TIMESTAMP_EN to add the free-running cycle
// counter and the stall_ts_o port.
// ---------------------------------------------------------------------------
module pc_stall_monitor
    import pcmon_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int CH       = 1,
    parameter int THRESH_W = 16,
    parameter int CH_W     = (CH > 1 ? $clog2(CH) : 1)
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 en_i,
    input  logic [CH*PC_W-1:0]   pc_i,
    input  logic [CH-1:0]        valid_i,
    input  logic [THRESH_W-1:0]  thresh_i,
    input  logic                 clear_i,
    output logic [CH-1:0]        strobe_o,
    output logic [CH-1:0]        alarm_o,
    output logic                 alarm_any_o,
    output logic [PC_W-1:0]      stall_pc_o,
    output logic [CH_W-1:0]      stall_ch_o
`ifdef PCMON_TIMESTAMP_EN
    ,
    output logic [PCMON_TS_W-1:0] stall_ts_o
`endif
);

    logic [CH-1:0]   hit;
    logic [CH-1:0]   alarm_nxt;
    logic [PC_W-1:0] sel_pc;
    logic [CH_W-1:0] sel_ch;
    logic            capture;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        pcmon_chan #(
            .PC_W     (PC_W),
            .THRESH_W (THRESH_W)
        ) u_chan (
            .clk         (clk),
            .res_n       (res_n),
            .upd_i       (en_i & valid_i[c]),
            .pc_i        (pc_i[c*PC_W +: PC_W]),
            .thresh_i    (thresh_i),
            .clear_i     (clear_i),
            .hit_o       (hit[c]),
            .strobe_o    (strobe_o[c]),
            .alarm_o     (alarm_o[c]),
            .alarm_nxt_o (alarm_nxt[c])
        );
    end

    // Descending scan so the lowest hitting channel is the last to assign.
    always_comb begin
        sel_pc = '0;
        sel_ch = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (hit[c]) begin
                sel_pc = pc_i[c*PC_W +: PC_W];
                sel_ch = CH_W'(c);
            end
        end
    end

    // Capture only the first alarm; a same-edge clear makes the slot free.
    assign capture = (!alarm_any_o || clear_i) && (hit != '0);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            alarm_any_o <= 1'b0;
            stall_pc_o  <= '0;
            stall_ch_o  <= '0;
        end else begin
            alarm_any_o <= |alarm_nxt;
            if (capture) begin
                stall_pc_o <= sel_pc;
                stall_ch_o <= sel_ch;
            end else if (clear_i) begin
                stall_pc_o <= '0;
                stall_ch_o <= '0;
            end
        end
    end

`ifdef PCMON_TIMESTAMP_EN
    logic [PCMON_TS_W-1:0] ts_cnt;

    // The stored stamp is the value the counter takes on the alarming edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ts_cnt     <= '0;
            stall_ts_o <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (capture) begin
                stall_ts_o <= ts_cnt + 32'd1;
            end else if (clear_i) begin
                stall_ts_o <= '0;
            end
        end
    end
`else
    // No timestamp hardware in this build.
`endif

endmodule

// File: tb/tb_pc_stall_monitor.sv
// ---------------------------------------------------------------------------
// tb_pc_stall_monitor
// Self-checking bench for pc_stall_monitor with four channels. A simple
// run-length model of each channel's PC history predicts strobes, alarms
// and the first-alarm capture.
// ---------------------------------------------------------------------------
module tb_pc_stall_monitor;
    import pcmon_pkg::*;

    localparam int PC_W = 16;
    localparam int CH   = 4;
    localparam int TW   = 16;
    localparam int CH_W = 2;

    logic               clk = 1'b0;
    logic               res_n = 1'b0;
    logic               en_i = 1'b0;
    logic [CH*PC_W-1:0] pc_i = '0;
    logic [CH-1:0]      valid_i = '0;
    logic [TW-1:0]      thresh_i = '0;
    logic               clear_i = 1'b0;
    logic [CH-1:0]      strobe_o;
    logic [CH-1:0]      alarm_o;
    logic               alarm_any_o;
    logic [PC_W-1:0]    stall_pc_o;
    logic [CH_W-1:0]    stall_ch_o;
`ifdef PCMON_TIMESTAMP_EN
    logic [31:0]        stall_ts_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: per channel, whether a PC was seen, the last PC and
    // how many times in a row it repeated on qualified cycles.
    bit              m_seen [CH];
    logic [PC_W-1:0] m_last [CH];
    int              m_run  [CH];
    logic [CH-1:0]   m_strobe;
    logic [CH-1:0]   m_alarm;
    logic [PC_W-1:0] m_pc;
    logic [CH_W-1:0] m_ch;
    logic [31:0]     m_time;
    logic [31:0]     m_ts;

    pc_stall_monitor #(
        .PC_W     (PC_W),
        .CH       (CH),
        .THRESH_W (TW),
        .CH_W     (CH_W)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .en_i        (en_i),
        .pc_i        (pc_i),
        .valid_i     (valid_i),
        .thresh_i    (thresh_i),
        .clear_i     (clear_i),
        .strobe_o    (strobe_o),
        .alarm_o     (alarm_o),
        .alarm_any_o (alarm_any_o),
        .stall_pc_o  (stall_pc_o),
        .stall_ch_o  (stall_ch_o)
`ifdef PCMON_TIMESTAMP_EN
        ,
        .stall_ts_o  (stall_ts_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [PC_W-1:0] pc_of(int c);
        return pc_i[c*PC_W +: PC_W];
    endfunction

    task automatic set_pc(int c, logic [PC_W-1:0] v);
        pc_i[c*PC_W +: PC_W] = v;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_seen[c] = 1'b0;
            m_last[c] = '0;
            m_run[c]  = 0;
        end
        m_strobe = '0;
        m_alarm  = '0;
        m_pc     = '0;
        m_ch     = '0;
        m_time   = '0;
        m_ts     = '0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] hit;
        int            thr;
        bit            any_before;
        bit            found;
        hit        = '0;
        thr        = int'(thresh_i);
        any_before = (m_alarm != '0);
        found      = 1'b0;
        m_time     = m_time + 32'd1;
        for (int c = 0; c < CH; c++) begin
            if (en_i && valid_i[c]) begin
                if (!m_seen[c]) begin
                    m_seen[c] = 1'b1;
                    m_last[c] = pc_of(c);
                    m_run[c]  = 0;
                end else begin
                    if (pc_of(c) == m_last[c]) begin
                        if (m_run[c] < 65535) m_run[c] = m_run[c] + 1;
                    end else begin
                        m_last[c] = pc_of(c);
                        m_run[c]  = 0;
                    end
                    if (!m_alarm[c] && thr != 0 && m_run[c] >= thr) hit[c] = 1'b1;
                end
            end
        end
        if ((!any_before || clear_i) && hit != '0) begin
            for (int c = 0; c < CH; c++) begin
                if (hit[c] && !found) begin
                    found = 1'b1;
                    m_pc  = pc_of(c);
                    m_ch  = CH_W'(c);
                    m_ts  = m_time;
                end
            end
        end else if (clear_i) begin
            m_pc = '0;
            m_ch = '0;
            m_ts = '0;
        end
        if (clear_i) begin
            for (int c = 0; c < CH; c++) if (m_alarm[c]) m_run[c] = 0;
            m_alarm = hit;
        end else begin
            m_alarm = m_alarm | hit;
        end
        m_strobe = hit;
    endtask

    // One clock edge: update the model from the inputs present at the edge,
    // then step 1 time unit past the edge for sampling and new stimulus.
    task automatic tick();
        @(posedge clk);
        if (res_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        res_n    = 1'b0;
        en_i     = 1'b0;
        valid_i  = '0;
        pc_i     = '0;
        thresh_i = '0;
        clear_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (strobe_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0000", strobe_o); end
        checks++;
        if (alarm_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_alarm: got %b expected 0000", alarm_o); end
        checks++;
        if (alarm_any_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_any: got %b expected 0", alarm_any_o); end
        checks++;
        if (stall_pc_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0000", stall_pc_o); end
        checks++;
        if (stall_ch_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d expected 0", stall_ch_o); end
    endtask

    task automatic test_basic_stall();
        do_reset();
        thresh_i = TW'(PCMON_THRESH_DEF);
        en_i     = 1'b1;
        valid_i  = 4'b0001;
        set_pc(0, 16'h0200);
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++;
            if (strobe_o[0] !== (e == 26)) begin
                errors++; $display("[TB] FAIL basic_strobe edge %0d: got %b expected %b", e, strobe_o[0], (e == 26));
            end
            checks++;
            if (alarm_o[0] !== (e >= 26)) begin
                errors++; $display("[TB] FAIL basic_alarm edge %0d: got %b expected %b", e, alarm_o[0], (e >= 26));
            end
        end
        checks++;
        if (stall_pc_o !== 16'h0200) begin errors++; $display("[TB] FAIL basic_pc: got %h expected 0200", stall_pc_o); end
        checks++;
        if (stall_ch_o !== 2'd0) begin errors++; $display("[TB] FAIL basic_ch: got %0d expected 0", stall_ch_o); end
        checks++;
        if (alarm_any_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_any: got %b expected 1", alarm_any_o); end
    endtask

    task automatic test_no_stall();
        do_reset();
        thresh_i = 16'd25;
        en_i     = 1'b1;
        valid_i  = 4'b0001;
        for (int i = 0; i < 1000; i++) begin
            set_pc(0, 16'(i));
            tick();
            checks++;
            if ({strobe_o, alarm_o} !== 8'h00) begin
                errors++; $display("[TB] FAIL nostall cycle %0d: got strobe %b alarm %b expected 0", i, strobe_o, alarm_o);
            end
        end
    endtask

    task automatic test_valid_pause();
        int  q;
        logic v;
        do_reset();
        q        = 0;
        thresh_i = 16'd25;
        en_i     = 1'b1;
        set_pc(0, 16'h1234);
        for (int e = 1; e <= 50; e++) begin
            v = !(e > 20 && e <= 30);
            valid_i[0] = v;
            tick();
            if (v) q++;
            checks++;
            if (strobe_o[0] !== (v && q == 26)) begin
                errors++; $display("[TB] FAIL pause_strobe edge %0d: got %b expected %b", e, strobe_o[0], (v && q == 26));
            end
            checks++;
            if (alarm_o[0] !== (q >= 26)) begin
                errors++; $display("[TB] FAIL pause_alarm edge %0d: got %b expected %b", e, alarm_o[0], (q >= 26));
            end
        end
    endtask

    task automatic test_multi_channel();
        do_reset();
        thresh_i = 16'd10;
        en_i     = 1'b1;
        valid_i  = 4'b1101;
        set_pc(2, 16'h2222);
        set_pc(3, 16'h3333);
        for (int e = 1; e <= 30; e++) begin
            set_pc(0, (e <= 15) ? 16'(e) : 16'h00F0);
            tick();
            checks++;
            if (strobe_o !== m_strobe || alarm_o !== m_alarm || stall_ch_o !== m_ch || stall_pc_o !== m_pc) begin
                errors++;
                $display("[TB] FAIL multi_model edge %0d: got s=%b a=%b ch=%0d pc=%h expected s=%b a=%b ch=%0d pc=%h",
                         e, strobe_o, alarm_o, stall_ch_o, stall_pc_o, m_strobe, m_alarm, m_ch, m_pc);
            end
            if (e == 11) begin
                checks++;
                if (strobe_o !== 4'b1100) begin errors++; $display("[TB] FAIL multi_dual_strobe: got %b expected 1100", strobe_o); end
                checks++;
                if (stall_ch_o !== 2'd2 || stall_pc_o !== 16'h2222) begin
                    errors++; $display("[TB] FAIL multi_capture: got ch=%0d pc=%h expected ch=2 pc=2222", stall_ch_o, stall_pc_o);
                end
            end
            if (e == 26) begin
                checks++;
                if (strobe_o !== 4'b0001) begin errors++; $display("[TB] FAIL multi_ch0_strobe: got %b expected 0001", strobe_o); end
            end
        end
        checks++;
        if (stall_ch_o !== 2'd2 || stall_pc_o !== 16'h2222 || alarm_o !== 4'b1101) begin
            errors++; $display("[TB] FAIL multi_keep: got ch=%0d pc=%h a=%b expected ch=2 pc=2222 a=1101", stall_ch_o, stall_pc_o, alarm_o);
        end
    endtask

    task automatic test_clear_same_edge();
        do_reset();
        thresh_i = 16'd8;
        en_i     = 1'b1;
        set_pc(0, 16'h0A0A);
        set_pc(1, 16'h0B0B);
        for (int e = 1; e <= 13; e++) begin
            valid_i = (e >= 4) ? 4'b0011 : 4'b0001;
            clear_i = (e == 12 || e == 13);
            tick();
            checks++;
            if (strobe_o !== m_strobe || alarm_o !== m_alarm || stall_ch_o !== m_ch || stall_pc_o !== m_pc) begin
                errors++;
                $display("[TB] FAIL clear_model edge %0d: got s=%b a=%b ch=%0d pc=%h expected s=%b a=%b ch=%0d pc=%h",
                         e, strobe_o, alarm_o, stall_ch_o, stall_pc_o, m_strobe, m_alarm, m_ch, m_pc);
            end
            if (e == 9) begin
                checks++;
                if (alarm_o !== 4'b0001 || stall_ch_o !== 2'd0) begin
                    errors++; $display("[TB] FAIL clear_pre: got a=%b ch=%0d expected a=0001 ch=0", alarm_o, stall_ch_o);
                end
            end
            if (e == 12) begin
                checks++;
                if (alarm_o !== 4'b0010 || strobe_o !== 4'b0010 || stall_ch_o !== 2'd1 || stall_pc_o !== 16'h0B0B) begin
                    errors++;
                    $display("[TB] FAIL clear_set_wins: got a=%b s=%b ch=%0d pc=%h expected a=0010 s=0010 ch=1 pc=0b0b",
                             alarm_o, strobe_o, stall_ch_o, stall_pc_o);
                end
            end
            if (e == 13) begin
                checks++;
                if (alarm_o !== 4'b0000 || alarm_any_o !== 1'b0 || stall_ch_o !== 2'd0 || stall_pc_o !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL clear_alone: got a=%b any=%b ch=%0d pc=%h expected all 0",
                             alarm_o, alarm_any_o, stall_ch_o, stall_pc_o);
                end
            end
        end
        clear_i = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        thresh_i = 16'd25;
        en_i     = 1'b1;
        set_pc(0, 16'h0300);
        set_pc(1, 16'h0301);
        for (int e = 1; e <= 27; e++) begin
            valid_i = (e >= 7) ? 4'b0011 : 4'b0010;
            tick();
        end
        checks++;
        if (alarm_o !== 4'b0010 || stall_ch_o !== 2'd1 || stall_pc_o !== 16'h0301) begin
            errors++; $display("[TB] FAIL areset_pre: got a=%b ch=%0d pc=%h expected a=0010 ch=1 pc=0301", alarm_o, stall_ch_o, stall_pc_o);
        end
        #3;
        res_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (strobe_o !== 4'b0000 || alarm_o !== 4'b0000 || alarm_any_o !== 1'b0 ||
            stall_pc_o !== 16'h0000 || stall_ch_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got s=%b a=%b any=%b pc=%h ch=%0d expected all 0",
                     strobe_o, alarm_o, alarm_any_o, stall_pc_o, stall_ch_o);
        end
`ifdef PCMON_TIMESTAMP_EN
        checks++;
        if (stall_ts_o !== 32'd0) begin errors++; $display("[TB] FAIL areset_ts: got %0d expected 0", stall_ts_o); end
`endif
        valid_i = 4'b0001;
        @(posedge clk);
        #1;
        res_n = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            checks++;
            if (strobe_o[0] !== (e == 26)) begin
                errors++; $display("[TB] FAIL areset_restrobe edge %0d: got %b expected %b", e, strobe_o[0], (e == 26));
            end
`ifdef PCMON_TIMESTAMP_EN
            if (e == 26) begin
                checks++;
                if (stall_ts_o !== 32'd26) begin errors++; $display("[TB] FAIL areset_ts26: got %0d expected 26", stall_ts_o); end
            end
`endif
        end
    endtask

    task automatic test_thresh_change();
        bit seen_alarm;
        do_reset();
        thresh_i = 16'd25;
        en_i     = 1'b1;
        valid_i  = 4'b0001;
        set_pc(0, 16'h0400);
        repeat (15) tick();
        thresh_i = 16'd5;
        tick();
        checks++;
        if (strobe_o[0] !== 1'b1 || alarm_o[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL lower_thresh: got s=%b a=%b expected s=1 a=1", strobe_o[0], alarm_o[0]);
        end
        thresh_i = 16'd0;
        repeat (3) tick();
        checks++;
        if (alarm_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL thresh0_hold: got %b expected 1", alarm_o[0]); end
        do_reset();
        en_i       = 1'b1;
        valid_i    = 4'b1111;
        seen_alarm = 1'b0;
        repeat (40) begin
            tick();
            if (strobe_o != '0 || alarm_o != '0) seen_alarm = 1'b1;
        end
        checks++;
        if (seen_alarm !== 1'b0) begin errors++; $display("[TB] FAIL thresh0_disabled: got alarm activity %b expected 0", seen_alarm); end
    endtask

    task automatic test_random();
        do_reset();
        thresh_i = 16'd6;
        for (int c = 0; c < CH; c++) set_pc(c, 16'($urandom_range(0, 3)));
        for (int i = 0; i < 3000; i++) begin
            en_i    = ($urandom_range(0, 9) != 0);
            valid_i = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) set_pc(c, 16'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 199) == 0) thresh_i = TW'($urandom_range(0, 12));
            clear_i = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (strobe_o !== m_strobe || alarm_o !== m_alarm || alarm_any_o !== (m_alarm != '0) ||
                stall_ch_o !== m_ch || stall_pc_o !== m_pc) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got s=%b a=%b any=%b ch=%0d pc=%h expected s=%b a=%b ch=%0d pc=%h",
                         i, strobe_o, alarm_o, alarm_any_o, stall_ch_o, stall_pc_o, m_strobe, m_alarm, m_ch, m_pc);
            end
`ifdef PCMON_TIMESTAMP_EN
            checks++;
            if (stall_ts_o !== m_ts) begin
                errors++; $display("[TB] FAIL random_ts cycle %0d: got %0d expected %0d", i, stall_ts_o, m_ts);
            end
`endif
        end
        clear_i = 1'b0;
    endtask

    initial begin
        $display("[TB] pc_stall_monitor bench start");
        test_reset();
        test_basic_stall();
        test_no_stall();
        test_valid_pause();
        test_multi_channel();
        test_clear_same_edge();
        test_async_reset();
        test_thresh_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
